// File: rtl/lib_set_clear_flag.sv
// Per-bit set/clear flag register: set wins on collision, one-cycle latency, output purely registered.
// No backpressure: every edge samples set/clear; synchronous active-low reset loads RST_VAL.
module lib_set_clear_flag #(
  parameter int unsigned            WIDTH   = 1,
  parameter logic [WIDTH-1:0]       RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] flag
);

  logic [WIDTH-1:0] flag_nxt;

  // Set overrides clear so a slot can be consumed and refilled in the same cycle.
  always_comb begin
    flag_nxt = set | (flag & ~clear);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag <= RST_VAL;
    end else begin
      flag <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_lib_set_clear_flag.sv
// Bench for lib_set_clear_flag: scalar and 4-bit instances against a per-bit rule model.
module tb_lib_set_clear_flag;

  logic       clk;
  logic       rst_n;
  logic       set1, clear1;
  logic       flag1;
  logic [3:0] set4, clear4;
  logic [3:0] flag4;

  bit         m1;
  bit   [3:0] m4;
  int         checks;
  int         failures;

  lib_set_clear_flag u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (set1),
    .clear (clear1),
    .flag  (flag1)
  );

  lib_set_clear_flag #(.WIDTH(4), .RST_VAL(4'b1010)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (set4),
    .clear (clear4),
    .flag  (flag4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model by the flag rules, compare both DUTs.
  task automatic step(input string tag, input logic r, input logic s1, input logic c1,
                      input logic [3:0] s4, input logic [3:0] c4);
    rst_n  = r;
    set1   = s1;
    clear1 = c1;
    set4   = s4;
    clear4 = c4;
    @(posedge clk);
    #1;
    if (!r) begin
      m1 = 1'b0;
      m4 = 4'b1010;
    end else begin
      if (s1 === 1'b1)      m1 = 1'b1;
      else if (c1 === 1'b1) m1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (s4[i] === 1'b1)      m4[i] = 1'b1;
        else if (c4[i] === 1'b1) m4[i] = 1'b0;
      end
    end
    check({tag, "_w1"}, {31'b0, flag1}, {31'b0, m1});
    check({tag, "_w4"}, {28'b0, flag4}, {28'b0, m4});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m1       = 1'b0;
    m4       = 4'b1010;
    rst_n    = 1'b0;
    set1     = 1'b1;
    clear1   = 1'b0;
    set4     = 4'bxxxx;
    clear4   = 4'bxxxx;

    // Reset held with set asserted (and unknown vector inputs) for two edges.
    step("rst_a", 1'b0, 1'b1, 1'b0, 4'bxxxx, 4'bxxxx);
    check("rst_val_w1", {31'b0, flag1}, 32'h0);
    check("rst_val_w4", {28'b0, flag4}, 32'ha);
    step("rst_b", 1'b0, 1'b1, 1'b0, 4'bxxxx, 4'bxxxx);
    step("idle_a", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Set pulse, hold five cycles, then clear pulse.
    step("set_pulse", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    check("set_visible", {31'b0, flag1}, 32'h1);
    for (int i = 0; i < 5; i++) step("hold_one", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step("clr_pulse", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    check("clr_visible", {31'b0, flag1}, 32'h0);

    // Collisions from 0 and from 1.
    step("coll_from0", 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    check("coll0_is1", {31'b0, flag1}, 32'h1);
    step("coll_from1", 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    check("coll1_is1", {31'b0, flag1}, 32'h1);

    // Redundant clear at 0 and repeated set.
    step("clr_to0", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    step("clr_redund", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step("set_redund", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Reset falling mid-cycle must not touch the flag before the edge.
    rst_n = 1'b0;
    #2;
    check("no_async_w1", {31'b0, flag1}, {31'b0, m1});
    check("no_async_w4", {28'b0, flag4}, {28'b0, m4});
    step("rst_mid", 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
    check("rst_mid_is0", {31'b0, flag1}, 32'h0);
    step("rel_set", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    check("rel_set_is1", {31'b0, flag1}, 32'h1);

    // Vector directed sequence from RST_VAL.
    step("vec_rst", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    check("vec_rst_val", {28'b0, flag4}, 32'ha);
    step("vec_a", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b1000);
    check("vec_a_val", {28'b0, flag4}, 32'h7);
    step("vec_b", 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0011);
    check("vec_b_val", {28'b0, flag4}, 32'h5);

    // Random run with occasional reset.
    for (int n = 0; n < 1000; n++) begin
      step("rand", ($urandom_range(49) != 0), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
